// File: rtl/mem_stage.sv
// Memory (ME) stage of the 5-stage MIPS pipeline: drives a req/ack data memory,
// steers byte/halfword lanes, extends loads and stalls upstream while waiting.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ans_ex,
  input  logic [31:0] b_ex,
  input  logic [4:0]  rw_ex,
  input  logic        wreg_ex,
  input  logic        m2reg_ex,
  input  logic        wmem_ex,
  input  logic [1:0]  msize_ex,
  input  logic        msign_ex,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ans_me,
  output logic [31:0] mo_me,
  output logic [4:0]  rw_me,
  output logic        wreg_me,
  output logic        m2reg_me,
  output logic        stall_me,
  output logic        align_err,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic        mem_op;
  logic        is_load;
  logic        misaligned;
  logic        go;
  logic [31:0] ld_ext;
  logic [31:0] ld_val;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // A load+store combination is treated as a load, so it never writes.
  assign mem_op     = m2reg_ex | wmem_ex;
  assign is_load    = m2reg_ex;
  assign misaligned = ((msize_ex == 2'b01) & ans_ex[0]) |
                      (msize_ex[1] & (ans_ex[1:0] != 2'b00));
  assign go         = mem_op & ~misaligned;

  assign dm_we     = wmem_ex & ~m2reg_ex;
  assign dm_addr   = ans_ex[31:2];
  assign ans_me    = ans_ex;
  assign rw_me     = rw_ex;
  assign state_dbg = state_q;

  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = b_ex;
    if (dm_we) begin
      case (msize_ex)
        2'b00: begin
          dm_be    = 4'b0001 << ans_ex[1:0];
          dm_wdata = {4{b_ex[7:0]}};
        end
        2'b01: begin
          dm_be    = ans_ex[1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{b_ex[15:0]}};
        end
        default: begin
          dm_be    = 4'b1111;
          dm_wdata = b_ex;
        end
      endcase
    end
  end

  // Little-endian lane select followed by sign or zero extension.
  always_comb begin
    ld_byte = dm_rdata[8*ans_ex[1:0] +: 8];
    ld_half = ans_ex[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (msize_ex)
      2'b00:   ld_ext = {{24{msign_ex & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{msign_ex & ld_half[15]}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
    ld_val = is_load ? ld_ext : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        cnt_d = '0;
        if (go) begin
          if (dm_ack) begin
            state_d = S_DONE;
            rdata_d = ld_val;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
      end
      S_ACCESS: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (dm_ack) begin
          state_d = S_DONE;
          rdata_d = ld_val;
        end else if (cnt_q == TO_LIM) begin
          state_d = S_DONE;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
    endcase
  end

  // Stalled cycles hand bubbles to WB; reset forces plain pass-through.
  always_comb begin
    dm_req    = 1'b0;
    stall_me  = 1'b0;
    wreg_me   = wreg_ex;
    m2reg_me  = m2reg_ex;
    mo_me     = 32'd0;
    align_err = 1'b0;
    bus_err   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (mem_op & misaligned) begin
            wreg_me   = 1'b0;
            align_err = 1'b1;
          end else if (go) begin
            dm_req   = 1'b1;
            stall_me = 1'b1;
            wreg_me  = 1'b0;
            m2reg_me = 1'b0;
          end
        end
        S_ACCESS: begin
          dm_req   = 1'b1;
          stall_me = 1'b1;
          wreg_me  = 1'b0;
          m2reg_me = 1'b0;
        end
        S_DONE: begin
          mo_me   = rdata_q;
          wreg_me = wreg_ex & ~err_q;
          bus_err = err_q;
        end
        default: begin
          wreg_me = wreg_ex;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction's cycle-by-cycle behaviour
// is predicted from the stage rules and compared against the DUT outputs.
module tb_mem_stage;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic        clock;
  logic        reset;
  logic [31:0] ans_ex;
  logic [31:0] b_ex;
  logic [4:0]  rw_ex;
  logic        wreg_ex;
  logic        m2reg_ex;
  logic        wmem_ex;
  logic [1:0]  msize_ex;
  logic        msign_ex;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] ans_me;
  logic [31:0] mo_me;
  logic [4:0]  rw_me;
  logic        wreg_me;
  logic        m2reg_me;
  logic        stall_me;
  logic        align_err;
  logic        bus_err;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_stage #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock(clock), .reset(reset),
    .ans_ex(ans_ex), .b_ex(b_ex), .rw_ex(rw_ex), .wreg_ex(wreg_ex),
    .m2reg_ex(m2reg_ex), .wmem_ex(wmem_ex), .msize_ex(msize_ex), .msign_ex(msign_ex),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ans_me(ans_me), .mo_me(mo_me), .rw_me(rw_me), .wreg_me(wreg_me),
    .m2reg_me(m2reg_me), .stall_me(stall_me), .align_err(align_err),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_nop();
    ans_ex = 32'd0; b_ex = 32'd0; rw_ex = 5'd0; wreg_ex = 1'b0;
    m2reg_ex = 1'b0; wmem_ex = 1'b0; msize_ex = 2'd2; msign_ex = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'd0;
  endtask

  // nwait < 0 means memory never acks; nwait > TIMEOUT also times out.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd,
                        input logic [4:0] rw, input logic wr, input logic m2r, input logic wm,
                        input logic [1:0] sz, input logic sg, input int nwait);
    logic memop, ld, st, mis, err;
    logic [31:0] lane, be, wd;
    int s;
    memop = m2r | wm;
    ld    = m2r;
    st    = wm & ~m2r;
    mis   = memop && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
    case (sz)
      2'd0: begin
        lane = (rd >> (8 * a[1:0])) & 32'hFF;
        if (sg && lane >= 32'h80) lane = lane + 32'hFFFF_FF00;
      end
      2'd1: begin
        lane = (rd >> (16 * a[1])) & 32'hFFFF;
        if (sg && lane >= 32'h8000) lane = lane + 32'hFFFF_0000;
      end
      default: lane = rd;
    endcase
    be = 32'hF;
    wd = b;
    if (st) begin
      case (sz)
        2'd0: begin be = 32'd1 << a[1:0]; wd = (b & 32'hFF) * 32'h0101_0101; end
        2'd1: begin be = 32'd3 << (2 * a[1]); wd = (b & 32'hFFFF) * 32'h0001_0001; end
        default: begin be = 32'hF; wd = b; end
      endcase
    end
    err = (nwait < 0) || (nwait > TIMEOUT);
    s   = err ? TIMEOUT + 1 : nwait + 1;

    @(posedge clock); #1;
    ans_ex = a; b_ex = b; rw_ex = rw; wreg_ex = wr; m2reg_ex = m2r; wmem_ex = wm;
    msize_ex = sz; msign_ex = sg; dm_rdata = rd; dm_ack = 1'b0;

    if (!memop || mis) begin
      @(negedge clock);
      chk("pt_ans", ans_me, a);
      chk("pt_rw", {27'd0, rw_me}, {27'd0, rw});
      chk("pt_req", {31'd0, dm_req}, 32'd0);
      chk("pt_stall", {31'd0, stall_me}, 32'd0);
      chk("pt_wreg", {31'd0, wreg_me}, {31'd0, wr & ~mis});
      chk("pt_m2reg", {31'd0, m2reg_me}, {31'd0, m2r});
      chk("pt_mo", mo_me, 32'd0);
      chk("pt_align", {31'd0, align_err}, {31'd0, mis});
      chk("pt_bus", {31'd0, bus_err}, 32'd0);
    end else begin
      exp_q.push_back(err ? 32'd0 : (ld ? lane : 32'd0));
      for (int k = 0; k <= s; k++) begin
        if (k > 0) begin @(posedge clock); #1; end
        dm_ack = (k == nwait);
        if (k == s) dm_rdata = $urandom;
        @(negedge clock);
        chk("ans", ans_me, a);
        chk("rw", {27'd0, rw_me}, {27'd0, rw});
        chk("align", {31'd0, align_err}, 32'd0);
        if (k < s) begin
          chk("st_req", {31'd0, dm_req}, 32'd1);
          chk("st_stall", {31'd0, stall_me}, 32'd1);
          chk("st_wreg", {31'd0, wreg_me}, 32'd0);
          chk("st_m2reg", {31'd0, m2reg_me}, 32'd0);
          chk("st_bus", {31'd0, bus_err}, 32'd0);
          chk("addr", {2'd0, dm_addr}, {2'd0, a[31:2]});
          chk("we", {31'd0, dm_we}, {31'd0, st});
          chk("be", {28'd0, dm_be}, be);
          if (st) chk("wdata", dm_wdata, wd);
        end else begin
          chk("dn_req", {31'd0, dm_req}, 32'd0);
          chk("dn_stall", {31'd0, stall_me}, 32'd0);
          chk("dn_wreg", {31'd0, wreg_me}, {31'd0, wr & ~err});
          chk("dn_m2reg", {31'd0, m2reg_me}, {31'd0, m2r});
          chk("dn_bus", {31'd0, bus_err}, {31'd0, err});
          chk("dn_mo", mo_me, exp_q.pop_front());
        end
      end
      dm_ack = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  kind_sz;
    int kind, nw;

    drive_nop();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_me}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_bus", {31'd0, bus_err}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // directed cases
    run_op(32'h1234, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 0);
    run_op(32'h103, 32'd0, 32'h80FF_0011, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2);
    run_op(32'h202, 32'h0000_ABCD, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0);
    run_op(32'h101, 32'd0, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 0);
    run_op(32'h100, 32'd0, 32'hDEAD_BEEF, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, -1);
    run_op(32'h104, 32'd0, 32'h1357_9BDF, 5'd6, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, TIMEOUT);
    run_op(32'h303, 32'h0000_0055, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1);

    // reset while waiting in ACCESS
    @(posedge clock); #1;
    ans_ex = 32'h8; rw_ex = 5'd9; wreg_ex = 1'b1; m2reg_ex = 1'b1; wmem_ex = 1'b0;
    msize_ex = 2'd2; dm_ack = 1'b0;
    @(negedge clock);
    chk("ra_stall0", {31'd0, stall_me}, 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("ra_stall1", {31'd0, stall_me}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("ra_req_rst", {31'd0, dm_req}, 32'd0);
    chk("ra_stall_rst", {31'd0, stall_me}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive_nop();
    wreg_ex = 1'b1;
    @(negedge clock);
    chk("ra_state", {30'd0, state_dbg}, 32'd0);
    chk("ra_req", {31'd0, dm_req}, 32'd0);
    chk("ra_stall", {31'd0, stall_me}, 32'd0);
    chk("ra_wreg", {31'd0, wreg_me}, 32'd1);
    chk("ra_bus", {31'd0, bus_err}, 32'd0);
    run_op(32'h2, 32'd0, 32'h8001_0000, 5'd2, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1);

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      kind    = $urandom_range(0, 9);
      kind_sz = 2'($urandom_range(0, 3));
      ra      = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'd0;
      nw = $urandom_range(0, TIMEOUT + 2);
      run_op(ra, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             (kind >= 2 && kind <= 5) || kind == 9, kind >= 6, kind_sz,
             1'($urandom_range(0, 1)), nw);
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_left got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
